// File: rtl/scroller_pkg.sv
// Shared types and sizes for the eight-digit scroller.
// State encoding and BRAM address widths used by the sequencer.
package scroller_pkg;

    typedef enum logic [1:0] {
        PROG   = 2'd0,
        FETCH  = 2'd1,
        LOAD   = 2'd2,
        SCROLL = 2'd3
    } state_e;

    localparam int ADDRA_W   = 2;
    localparam int ADDRB_W   = 1;
    localparam int HALFWORDS = 4;

endpackage

// File: rtl/scroll_sequencer_if.sv
// Control bundle between buttons/tick and the scroller datapath.
// master = sequencer side, slave = stimulus/datapath side.
interface scroll_sequencer_if;
    import scroller_pkg::*;

    logic               prog_btn;
    logic               write_btn;
    logic               tick;
    logic               pause;
    logic               wea;
    logic [ADDRA_W-1:0] addra;
    logic [ADDRB_W-1:0] addrb;
    logic               load_en;
    logic               shift_en;
    logic               disp_src;
    logic               word_idx;

    modport master (
        input  prog_btn, write_btn, tick, pause,
        output wea, addra, addrb, load_en, shift_en, disp_src, word_idx
    );

    modport slave (
        output prog_btn, write_btn, tick, pause,
        input  wea, addra, addrb, load_en, shift_en, disp_src, word_idx
    );

endinterface

// File: rtl/scroll_sequencer.sv
// Program / fetch / load / scroll controller for the scroller.
// Build option: define SCROLL_PAUSE_EN to let pause freeze scrolling.
module scroll_sequencer
    import scroller_pkg::*;
#(
    parameter int RD_LAT          = 1,
    parameter int SHIFTS_PER_WORD = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scroll_sequencer_if.master   bus
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [3:0] SHF_LAST = 4'(SHIFTS_PER_WORD - 1);

    state_e             state_q, state_d;
    logic [ADDRA_W-1:0] addra_q, addra_d;
    logic [ADDRB_W-1:0] addrb_q, addrb_d;
    logic               word_idx_q, word_idx_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [3:0]         shf_cnt_q, shf_cnt_d;
    logic               run;
    logic               wea, load_en, shift_en;

`ifdef SCROLL_PAUSE_EN
    assign run = ~bus.pause;
`else
    assign run = 1'b1;
`endif

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PROG;
            addra_q    <= '0;
            addrb_q    <= '0;
            word_idx_q <= 1'b0;
            lat_cnt_q  <= '0;
            shf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addra_q    <= addra_d;
            addrb_q    <= addrb_d;
            word_idx_q <= word_idx_d;
            lat_cnt_q  <= lat_cnt_d;
            shf_cnt_q  <= shf_cnt_d;
        end
    end

    // Next-state and strobe decode; prog_btn overrides every state.
    always_comb begin
        state_d    = state_q;
        addra_d    = addra_q;
        addrb_d    = addrb_q;
        word_idx_d = word_idx_q;
        lat_cnt_d  = lat_cnt_q;
        shf_cnt_d  = shf_cnt_q;
        wea        = 1'b0;
        load_en    = 1'b0;
        shift_en   = 1'b0;

        if (bus.prog_btn) begin
            state_d   = PROG;
            addra_d   = '0;
            lat_cnt_d = '0;
            shf_cnt_d = '0;
        end else begin
            unique case (state_q)
                PROG: begin
                    if (bus.write_btn) begin
                        wea = 1'b1;
                        if (addra_q == ADDRA_W'(HALFWORDS - 1)) begin
                            addra_d   = '0;
                            addrb_d   = '0;
                            lat_cnt_d = '0;
                            state_d   = FETCH;
                        end else begin
                            addra_d = addra_q + 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        lat_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 2'd1;
                    end
                end
                LOAD: begin
                    load_en    = 1'b1;
                    word_idx_d = addrb_q;
                    shf_cnt_d  = '0;
                    state_d    = SCROLL;
                end
                SCROLL: begin
                    if (bus.tick && run) begin
                        shift_en = 1'b1;
                        if (shf_cnt_q == SHF_LAST) begin
                            shf_cnt_d = '0;
                            lat_cnt_d = '0;
                            addrb_d   = ~addrb_q;
                            state_d   = FETCH;
                        end else begin
                            shf_cnt_d = shf_cnt_q + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.wea      = wea & rst_n;
    assign bus.load_en  = load_en;
    assign bus.shift_en = shift_en;
    assign bus.addra    = addra_q;
    assign bus.addrb    = addrb_q;
    assign bus.word_idx = word_idx_q;
    assign bus.disp_src = (state_q == PROG);

endmodule
